// File: rtl/ssd_pkg.sv
// Shared constants, conversion FSM states and helpers for the seven-segment scan driver.
package ssd_pkg;

  localparam int unsigned SSD_DIGITS = 4;
  localparam int unsigned BCD_W      = 4 * SSD_DIGITS;

  localparam logic [13:0] BCD_MAX       = 14'd9999;
  localparam logic [3:0]  SSD_CTL_OFF   = 4'b1111;
  localparam logic [3:0]  SSD_CTL_FIRST = 4'b1110;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_e;

  // Add 3 to every nibble that is 5 or more, ahead of the double-dabble shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] r;
    r = acc;
    for (int i = 0; i < SSD_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) r[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [3:0] nibble_sel(input logic [BCD_W-1:0] bcd, input logic [1:0] idx);
    logic [BCD_W-1:0] s;
    s = bcd >> {idx, 2'b00};
    return s[3:0];
  endfunction

  // Slot idx is a leading zero when it and every nibble above it are zero; slot 0 never is.
  function automatic logic lz_blank(input logic [BCD_W-5:0] upper, input logic [1:0] idx);
    logic r;
    case (idx)
      2'd1:    r = (upper[11:0] == 12'd0);
      2'd2:    r = (upper[11:4] == 8'd0);
      2'd3:    r = (upper[11:8] == 4'd0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ssd_scan_driver_bin_to_bcd.sv
// Sequential double-dabble: one adjust-and-shift iteration per cycle, done pulses as the
// final accumulator becomes valid.
module bin_to_bcd
  import ssd_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  localparam int unsigned ITER_W = $clog2(BIN_W);

  conv_state_e       state;
  logic [BIN_W-1:0]  sr;
  logic [ITER_W-1:0] iter;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CONV_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      sr    <= '0;
      iter  <= '0;
    end else begin
      case (state)
        CONV_IDLE: begin
          if (start) begin
            sr    <= value;
            bcd   <= '0;
            iter  <= '0;
            busy  <= 1'b1;
            state <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          {bcd, sr} <= {dabble_adjust(bcd), sr} << 1;
          iter      <= iter + ITER_W'(1);
          if (iter == ITER_W'(BIN_W - 1)) begin
            done  <= 1'b1;
            state <= CONV_DONE;
          end
        end
        CONV_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= CONV_IDLE;
        end
        default: state <= CONV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit display front end: saturating load, BCD conversion, and a free-running
// digit scanner with optional leading-zero blanking.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned BIN_W    = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             load,
  input  logic             blank_lz,
  output logic             busy,
  output logic             ovf,
  output logic [15:0]      bcd,
  output logic [3:0]       digit,
  output logic [3:0]       ssd_ctl
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  logic             start_c;
  logic             over_c;
  logic [BIN_W-1:0] sat_c;
  logic [BCD_W-1:0] conv_bcd;
  logic             conv_done;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       slot;
  logic             wrap_c;
  logic [1:0]       nslot_c;

  assign start_c = load & ~busy;
  assign over_c  = (bin_in > BIN_W'(BCD_MAX));
  assign sat_c   = over_c ? BIN_W'(BCD_MAX) : bin_in;
  assign wrap_c  = (cnt == CNT_W'(SCAN_DIV - 1));
  assign nslot_c = wrap_c ? slot + 2'd1 : slot;

  bin_to_bcd #(.BIN_W(BIN_W)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .value (sat_c),
    .busy  (busy),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  // Display value, overflow flag and scan outputs; digit/ssd_ctl always reflect the slot
  // being entered so they change together on the wrap edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf     <= 1'b0;
      bcd     <= '0;
      cnt     <= '0;
      slot    <= 2'd0;
      digit   <= 4'd0;
      ssd_ctl <= SSD_CTL_FIRST;
    end else begin
      if (start_c)   ovf <= over_c;
      if (conv_done) bcd <= conv_bcd;
      cnt     <= wrap_c ? '0 : cnt + CNT_W'(1);
      slot    <= nslot_c;
      digit   <= nibble_sel(bcd, nslot_c);
      ssd_ctl <= (blank_lz && lz_blank(bcd[15:4], nslot_c)) ? SSD_CTL_OFF
                                                              : ~(4'b0001 << nslot_c);
    end
  end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Upstream front end for the four-digit seven-segment display. It accepts a 14-bit binary value on a load strobe and converts it to four BCD digits with a sequential double-dabble (shift-and-add-3) engine. It then time-multiplexes those digits onto the shared segment bus. Each cycle it presents one 4-bit BCD digit to the per-digit BCD-to-segment decoder and drives the matching active-low digit enable.

## Interface
Parameters:
- SCAN_DIV, default 100000: clock cycles per digit slot (about 1 kHz per digit at 100 MHz). Legal range is 2 or more. Benches use 4.
- BIN_W, default 14: binary input width. Fixed at 14; 9999 fits.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- bin_in  in  14  unsigned binary value to display.
- load  in  1  capture request; sampled on each rising edge.
- blank_lz  in  1  1 = blank leading zeros (level-sensitive, sampled every cycle).
- busy  out  1  conversion in progress; a load is accepted only when busy=0.
- ovf  out  1  last accepted value exceeded 9999 and was saturated.
- bcd  out  16  currently displayed value, four BCD nibbles; [3:0] = ones.
- digit  out  4  BCD nibble for the active slot; feeds the segment decoder.
- ssd_ctl  out  4  active-low digit enables; bit0 = ones (rightmost).

## Operation
- Reset values: busy=0, ovf=0, bcd=16'h0000, digit=4'd0, ssd_ctl=4'b1110, slot index=0, scan counter=0.
- Load acceptance:
  - load=1 at an edge where busy=0: capture min(bin_in, 9999) into the shift register.
  - ovf is set to (bin_in > 9999) at the same edge.
  - The BCD accumulator is cleared and busy goes to 1.
  - load=1 while busy=1 is ignored, with no queuing.
- Conversion: 14 iterations, one per cycle. Each iteration first adds 3 to every accumulator nibble that is ≥5, then shifts {accumulator, shift register} left by 1.
- Publish: after the 14th iteration, bcd is updated atomically and busy goes to 0. bcd holds its old value throughout the conversion.
- Scanner:
  - Free-running and independent of conversion.
  - The counter counts 0..SCAN_DIV-1. On wrap, the slot index advances 0→1→2→3→0.
  - Slot n drives digit=bcd[4n+3:4n] and ssd_ctl=~(4'b0001<<n).
- Leading-zero blanking (blank_lz=1): a slot n≥1 is blanked when its nibble and all higher nibbles are zero.
  - A blanked slot drives ssd_ctl=4'b1111; digit still carries the nibble.
  - Slot 0 is never blanked, so a value of 0 shows "0".
- Mid-operation reset: rst aborts any conversion and returns every output to its reset value on the same edge.

## Timing
- Load at edge k:
  - busy=1 after edge k.
  - Iterations run at edges k+1..k+14.
  - bcd is valid and busy=0 after edge k+15.
  - The earliest next accepted load is at edge k+16.
- ovf updates at edge k, at capture.
- digit and ssd_ctl are registered and change together on the wrap edge. Each slot lasts exactly SCAN_DIV cycles.
- A bcd publish mid-slot takes effect in digit and ssd_ctl at the next edge, with no glitch state between.
- Full display refresh period is 4×SCAN_DIV cycles.
- rst takes priority over load and over the scanner.

## Structure
- Shared package ssd_pkg holds:
  - SSD_DIGITS=4
  - BCD_MAX=14'd9999
  - SSD_CTL_OFF=4'b1111
  - SSD_CTL_FIRST=4'b1110
- Sub-module bin_to_bcd holds the sequential double-dabble engine:
  - Inputs: clk, rst, start, 14-bit value.
  - Outputs: busy, 16-bit bcd, done pulse.
- The top level holds saturation, ovf, the scan counter, slot index, blanking and output registers.

## Test plan
- Reset check (SCAN_DIV=4): assert rst for 2 cycles → busy=0, ovf=0, bcd=16'h0000, ssd_ctl=4'b1110, digit=0.
- Basic conversion: load bin_in=1234 at edge k →
  - busy high for edges k..k+14.
  - bcd=16'h1234 after k+15.
  - ssd_ctl cycles 1110/1101/1011/0111 with digit 4/3/2/1, each for 4 cycles.
- Saturation: load bin_in=12000 → bcd=16'h9999, ovf=1. A following load of 42 → bcd=16'h0042, ovf=0.
- Leading-zero blanking: blank_lz=1, load 7 → slot0 ssd_ctl=1110 with digit=7, slots 1–3 ssd_ctl=1111. Then load 0 → slot0 shows digit 0 and slots 1–3 are blank. Then load 1005 → no slot is blanked.
- Load gating: a load at k+5 during a conversion is ignored and bcd reflects the first value. A load held continuously is re-accepted every 16 cycles.
- Reset mid-conversion: rst at k+7 → busy=0, bcd=0 after that edge. A subsequent load of 9999 → bcd=16'h9999 exactly 15 cycles later.
